// File: rtl/alu_sched_if.sv
// Bundle of requester, ALU and response signals around alu_sched.
// slave is the scheduler's view; master is the view of its surroundings.
interface alu_sched_if;
   logic        req0_valid;
   logic [2:0]  req0_op;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req0_ready;

   logic        req1_valid;
   logic [2:0]  req1_op;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        req1_ready;

   logic [2:0]  alu_op;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_out;

   logic        rsp_valid;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        rsp_ready;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
      output alu_op, alu_in1, alu_in2,
      input  alu_out,
      output rsp_valid, rsp_id, rsp_data, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
      input  alu_op, alu_in1, alu_in2,
      output alu_out,
      input  rsp_valid, rsp_id, rsp_data, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one combinational ALU between two requesters.
// Optional macro ALU_SCHED_OPCHECK_EN: reserved opcode 7 bypasses the ALU and returns rsp_err.
module alu_sched #(
   parameter int unsigned ISSUE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   alu_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  alu_op_q, alu_op_d;
   logic [31:0] alu_in1_q, alu_in1_d;
   logic [31:0] alu_in2_q, alu_in2_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;

   logic        grant;
   logic        accept;
   logic        op_rsvd;
   logic [2:0]  sel_op;
   logic [31:0] sel_a;
   logic [31:0] sel_b;

   always_comb begin
      // A tie goes to the port that did not win last time; a lone requester always wins.
      grant  = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
      accept = !rst && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
      sel_op = grant ? bus.req1_op : bus.req0_op;
      sel_a  = grant ? bus.req1_a  : bus.req0_a;
      sel_b  = grant ? bus.req1_b  : bus.req0_b;
`ifdef ALU_SCHED_OPCHECK_EN
      op_rsvd = (sel_op == 3'd7);
`else
      op_rsvd = 1'b0;
`endif
   end

   assign bus.req0_ready = accept && !grant;
   assign bus.req1_ready = accept && grant;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      alu_op_d     = alu_op_q;
      alu_in1_d    = alu_in1_q;
      alu_in2_d    = alu_in2_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               last_grant_d = grant;
               rsp_id_d     = grant;
               rsp_err_d    = op_rsvd;
               if (op_rsvd) begin
                  rsp_data_d  = '0;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  alu_op_d  = sel_op;
                  alu_in1_d = sel_a;
                  alu_in2_d = sel_b;
                  cnt_d     = 4'(ISSUE_CYCLES - 1);
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (cnt_q == 4'd0) begin
               rsp_data_d  = bus.alu_out;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         alu_op_q     <= '0;
         alu_in1_q    <= '0;
         alu_in2_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         alu_op_q     <= alu_op_d;
         alu_in1_q    <= alu_in1_d;
         alu_in2_q    <= alu_in2_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.alu_op    = alu_op_q;
   assign bus.alu_in1   = alu_in1_q;
   assign bus.alu_in2   = alu_in2_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: a transaction-level model predicts grants and responses,
// a monitor pops and compares each response; a second instance checks a longer settle time.
module tb_alu_sched;
   localparam int unsigned IC   = 1;
   localparam int unsigned IC_B = 4;
`ifdef ALU_SCHED_OPCHECK_EN
   localparam bit OPCHECK = 1'b1;
`else
   localparam bit OPCHECK = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } stim_t;

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        err;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_sched_if bus_a ();
   alu_sched_if bus_b ();

   alu_sched #(.ISSUE_CYCLES(IC))   dut   (.clk(clk), .rst(rst), .bus(bus_a.slave));
   alu_sched #(.ISSUE_CYCLES(IC_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   // Behavioural ALU seen by both schedulers; opcode 7 yields an arbitrary marker value.
   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [15:0] ah;
      logic signed [15:0] bh;
      logic signed [31:0] p;
      ah = a[15:0];
      bh = b[15:0];
      p  = ah * bh;
      case (op)
         3'd0:    return b;
         3'd1:    return a;
         3'd2:    return a + b;
         3'd3:    return p;
         3'd4:    return {31'b0, a == b};
         3'd5:    return {31'b0, $signed(a) < $signed(b)};
         3'd6:    return -b;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign bus_a.alu_out = alu_fn(bus_a.alu_op, bus_a.alu_in1, bus_a.alu_in2);
   assign bus_b.alu_out = alu_fn(bus_b.alu_op, bus_b.alu_in1, bus_b.alu_in2);

   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   exp_t  sbq[$];
   stim_t sq0[$];
   stim_t sq1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Model: predicts readies and ALU inputs, pushes the expected response on each accept.
   logic        m_busy, m_last, m_g, m_e0, m_e1, m_rsvd;
   logic [2:0]  m_op, m_sop;
   logic [31:0] m_a, m_b, m_sa, m_sb;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            sbq.delete();
            m_busy = 1'b0;
            m_last = 1'b1;
            m_op   = '0;
            m_a    = '0;
            m_b    = '0;
         end else begin
            m_g  = (bus_a.req0_valid && bus_a.req1_valid) ? !m_last : bus_a.req1_valid;
            m_e0 = !m_busy && bus_a.req0_valid && !m_g;
            m_e1 = !m_busy && bus_a.req1_valid && m_g;
            check("req0_ready", {31'b0, bus_a.req0_ready}, {31'b0, m_e0});
            check("req1_ready", {31'b0, bus_a.req1_ready}, {31'b0, m_e1});
            check("alu_op", {29'b0, bus_a.alu_op}, {29'b0, m_op});
            check("alu_in1", bus_a.alu_in1, m_a);
            check("alu_in2", bus_a.alu_in2, m_b);
            if (m_e0 || m_e1) begin
               m_sop  = m_g ? bus_a.req1_op : bus_a.req0_op;
               m_sa   = m_g ? bus_a.req1_a  : bus_a.req0_a;
               m_sb   = m_g ? bus_a.req1_b  : bus_a.req0_b;
               m_rsvd = OPCHECK && (m_sop == 3'd7);
               sbq.push_back('{id: m_g, data: m_rsvd ? 32'h0 : alu_fn(m_sop, m_sa, m_sb),
                               err: m_rsvd, acc: cyc});
               if (!m_rsvd) begin
                  m_op = m_sop;
                  m_a  = m_sa;
                  m_b  = m_sb;
               end
               m_busy = 1'b1;
               m_last = m_g;
            end else if (bus_a.rsp_valid && bus_a.rsp_ready) begin
               m_busy = 1'b0;
            end
         end
      end
   end

   // Monitor: reset values while rst is high; pops and compares every response handshake.
   logic mon_in_resp;
   int   mon_start;
   exp_t mon_e;
   initial begin
      mon_in_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_in_resp = 1'b0;
            check("rst_req0_ready", {31'b0, bus_a.req0_ready}, 32'd0);
            check("rst_req1_ready", {31'b0, bus_a.req1_ready}, 32'd0);
            check("rst_alu_op", {29'b0, bus_a.alu_op}, 32'd0);
            check("rst_alu_in1", bus_a.alu_in1, 32'd0);
            check("rst_alu_in2", bus_a.alu_in2, 32'd0);
            check("rst_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
            check("rst_rsp_id", {31'b0, bus_a.rsp_id}, 32'd0);
            check("rst_rsp_data", bus_a.rsp_data, 32'd0);
            check("rst_rsp_err", {31'b0, bus_a.rsp_err}, 32'd0);
         end else if (bus_a.rsp_valid) begin
            if (!mon_in_resp) begin
               mon_in_resp = 1'b1;
               mon_start   = cyc;
            end
            if (bus_a.rsp_ready) begin
               mon_in_resp = 1'b0;
               if (sbq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rsp_unexpected: got id %0d data 0x%08h expected no response",
                           bus_a.rsp_id, bus_a.rsp_data);
               end else begin
                  mon_e = sbq.pop_front();
                  check("rsp_id", {31'b0, bus_a.rsp_id}, {31'b0, mon_e.id});
                  check("rsp_data", bus_a.rsp_data, mon_e.data);
                  check("rsp_err", {31'b0, bus_a.rsp_err}, {31'b0, mon_e.err});
                  check("rsp_latency", mon_start - mon_e.acc - 1, mon_e.err ? 0 : IC);
               end
            end
         end
      end
   end

   // Driver: one cycle; a port takes its next queued request once the current one is accepted.
   logic  a0, a1;
   stim_t s;
   task automatic step();
      @(negedge clk);
      a0 = bus_a.req0_valid && bus_a.req0_ready;
      a1 = bus_a.req1_valid && bus_a.req1_ready;
      @(posedge clk);
      #1;
      if (a0 || !bus_a.req0_valid) begin
         if (sq0.size() != 0) begin
            s = sq0.pop_front();
            bus_a.req0_valid = 1'b1;
            bus_a.req0_op    = s.op;
            bus_a.req0_a     = s.a;
            bus_a.req0_b     = s.b;
         end else begin
            bus_a.req0_valid = 1'b0;
         end
      end
      if (a1 || !bus_a.req1_valid) begin
         if (sq1.size() != 0) begin
            s = sq1.pop_front();
            bus_a.req1_valid = 1'b1;
            bus_a.req1_op    = s.op;
            bus_a.req1_a     = s.a;
            bus_a.req1_b     = s.b;
         end else begin
            bus_a.req1_valid = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus_a.rsp_ready = 1'b1;
      while ((sq0.size() != 0 || sq1.size() != 0 || bus_a.req0_valid || bus_a.req1_valid ||
              sbq.size() != 0 || bus_a.rsp_valid) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
      end
   endtask

   function automatic stim_t rand_stim();
      stim_t r;
      r.op = 3'($urandom_range(0, 7));
      r.a  = $urandom;
      r.b  = ($urandom_range(0, 3) == 0) ? r.a : $urandom;
      return r;
   endfunction

   task automatic reset_pulse();
      @(posedge clk);
      #1 rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   int n_wait;
   int lat_b;
   initial begin
      rst = 1'b1;
      bus_a.req0_valid = 1'b0; bus_a.req0_op = '0; bus_a.req0_a = '0; bus_a.req0_b = '0;
      bus_a.req1_valid = 1'b0; bus_a.req1_op = '0; bus_a.req1_a = '0; bus_a.req1_b = '0;
      bus_a.rsp_ready  = 1'b1;
      bus_b.req0_valid = 1'b0; bus_b.req0_op = '0; bus_b.req0_a = '0; bus_b.req0_b = '0;
      bus_b.req1_valid = 1'b0; bus_b.req1_op = '0; bus_b.req1_a = '0; bus_b.req1_b = '0;
      bus_b.rsp_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Port 0 alone: 5 + -7.
      sq0.push_back('{op: 3'd2, a: 32'd5, b: -32'sd7});
      drain();

      // Both ports valid from reset: ties alternate 0,1,0,1.
      reset_pulse();
      sq0.push_back('{op: 3'd3, a: 32'h0001_FFFF, b: 32'd3});
      sq0.push_back('{op: 3'd3, a: 32'h0001_FFFF, b: 32'd3});
      sq1.push_back('{op: 3'd4, a: 32'd9, b: 32'd9});
      sq1.push_back('{op: 3'd4, a: 32'd9, b: 32'd9});
      drain();

      // Consumer stall for 5 cycles with the other port waiting.
      bus_a.rsp_ready = 1'b0;
      sq0.push_back('{op: 3'd1, a: 32'h1234_5678, b: 32'h0});
      sq1.push_back('{op: 3'd5, a: 32'hFFFF_FFFF, b: 32'd1});
      n_wait = 0;
      while (!bus_a.rsp_valid && n_wait < 20) begin
         step();
         n_wait++;
      end
      check("stall_rsp_seen", {31'b0, bus_a.rsp_valid}, 32'd1);
      repeat (5) step();
      drain();

      // Reserved opcode.
      sq0.push_back('{op: 3'd7, a: 32'h0000_00AA, b: 32'h0000_0055});
      drain();

      // Reset while an operation is in ISSUE; the next tie must go to port 0.
      sq0.push_back('{op: 3'd2, a: 32'd100, b: 32'd1});
      sq0.push_back('{op: 3'd0, a: 32'd0, b: 32'h0BAD_F00D});
      sq1.push_back('{op: 3'd6, a: 32'd0, b: 32'd1});
      n_wait = 0;
      a0 = 1'b0;
      a1 = 1'b0;
      while (!(a0 || a1) && n_wait < 20) begin
         step();
         n_wait++;
      end
      check("pre_rst_accept", {31'b0, a0 || a1}, 32'd1);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      drain();

      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         if (sq0.size() == 0 && $urandom_range(0, 1) == 1) sq0.push_back(rand_stim());
         if (sq1.size() == 0 && $urandom_range(0, 1) == 1) sq1.push_back(rand_stim());
         bus_a.rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();
      check("scoreboard_empty", sbq.size(), 32'd0);

      // Second instance, settle time 4: negate 0x8000_0000.
      bus_b.req0_valid = 1'b1;
      bus_b.req0_op    = 3'd6;
      bus_b.req0_a     = 32'h0000_0011;
      bus_b.req0_b     = 32'h8000_0000;
      n_wait = 0;
      do begin
         @(negedge clk);
         n_wait++;
      end while (!bus_b.req0_ready && n_wait < 20);
      check("b_accept", {31'b0, bus_b.req0_ready}, 32'd1);
      @(posedge clk);
      #1 bus_b.req0_valid = 1'b0;
      lat_b = 0;
      do begin
         @(negedge clk);
         lat_b++;
      end while (!bus_b.rsp_valid && lat_b < 20);
      check("b_latency", lat_b - 1, IC_B);
      check("b_rsp_data", bus_b.rsp_data, 32'h8000_0000);
      check("b_rsp_id", {31'b0, bus_b.rsp_id}, 32'd0);
      check("b_alu_in2", bus_b.alu_in2, 32'h8000_0000);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("b_rsp_cleared", {31'b0, bus_b.rsp_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
